traffic_junction_ctrl: RTL and testbench

- Parametrised multi-way traffic-light controller; successor to the single-way red/amber/green sequencer.
- Drives NUM_WAYS approaches in round-robin using the UK sequence red -> red+amber -> green -> amber -> red, with an all-red clearance interval between ways.
- Adds a latched pedestrian request, served as an all-traffic-red walk phase, and a flashing-amber mode selected when `en` is low.
- Sits directly under the exercise top level; outputs drive LED/lamp pins.

---
 rtl/traffic_junction_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_traffic_junction_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_junction_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_junction_ctrl
//
// Multi-way traffic-light controller. Approaches are served in round-robin
// using the UK sequence red -> red+amber -> green -> amber -> red, with an
// all-red clearance interval between ways. A latched pedestrian request is
// served as an all-traffic-red walk phase taken at the end of a clearance
// interval. Dropping en puts every approach into flashing amber.
//
// Ports:
//   clk        in   rising-edge system clock
//   rst_n      in   asynchronous active-low reset (release synchronous)
//   en         in   1 = normal sequencing, 0 = flashing-amber mode
//   ped_req    in   pedestrian button, any high cycle latches a request
//   red        out  [NUM_WAYS] per-way red lamp
//   amber      out  [NUM_WAYS] per-way amber lamp
//   green      out  [NUM_WAYS] per-way green lamp
//   walk       out  pedestrian walk lamp
//   ped_wait   out  pedestrian request latched and not yet served
//   active_way out  [WAY_W] index of the way currently being sequenced
//
// All outputs are decoded from registered state only (Moore); en and
// ped_req never reach an output combinationally.
// ---------------------------------------------------------------------------
module traffic_junction_ctrl #(
  parameter int NUM_WAYS         = 2,
  parameter int CNT_W            = 8,
  parameter int RED_AMBER_CYCLES = 2,
  parameter int GREEN_CYCLES     = 8,
  parameter int AMBER_CYCLES     = 3,
  parameter int ALL_RED_CYCLES   = 1,
  parameter int WALK_CYCLES      = 6,
  parameter int FLASH_CYCLES     = 4,
  localparam int WAY_W           = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                ped_req,
  output logic [NUM_WAYS-1:0] red,
  output logic [NUM_WAYS-1:0] amber,
  output logic [NUM_WAYS-1:0] green,
  output logic                walk,
  output logic                ped_wait,
  output logic [WAY_W-1:0]    active_way
);

  typedef enum logic [2:0] {
    S_ALL_RED,
    S_RED_AMBER,
    S_GREEN,
    S_AMBER,
    S_PED_WALK,
    S_FLASH
  } state_t;

  // Terminal timer values: a phase of N cycles ends when the timer reads N-1.
  localparam logic [CNT_W-1:0] RA_LAST    = CNT_W'(RED_AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] AMBER_LAST = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [WAY_W-1:0] WAY_LAST   = WAY_W'(NUM_WAYS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [WAY_W-1:0] way_q,   way_d;
  logic             pend_q,  pend_d;
  logic             flash_q, flash_d;

  logic [CNT_W-1:0] last_cnt;
  logic             phase_end;
  logic [WAY_W-1:0] way_next;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ALL_RED;
      timer_q <= '0;
      way_q   <= '0;
      pend_q  <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      way_q   <= way_d;
      pend_q  <= pend_d;
      flash_q <= flash_d;
    end
  end

  // Length of the phase currently being timed (FLASH reuses the timer for
  // its half-period).
  always_comb begin
    last_cnt = AR_LAST;
    case (state_q)
      S_ALL_RED:   last_cnt = AR_LAST;
      S_RED_AMBER: last_cnt = RA_LAST;
      S_GREEN:     last_cnt = GREEN_LAST;
      S_AMBER:     last_cnt = AMBER_LAST;
      S_PED_WALK:  last_cnt = WALK_LAST;
      S_FLASH:     last_cnt = FLASH_LAST;
      default:     last_cnt = AR_LAST;
    endcase
  end

  assign phase_end = (timer_q == last_cnt);
  assign way_next  = (way_q == WAY_LAST) ? '0 : way_q + WAY_W'(1);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + CNT_W'(1);
    way_d   = way_q;
    flash_d = flash_q;

    if (!en) begin
      if (state_q != S_FLASH) begin
        // Entry into flash: first half-period is lit.
        state_d = S_FLASH;
        timer_d = '0;
        flash_d = 1'b1;
      end else if (phase_end) begin
        timer_d = '0;
        flash_d = ~flash_q;
      end
    end else begin
      case (state_q)
        S_FLASH: begin
          // Leaving flash restarts the junction from a clean all-red.
          state_d = S_ALL_RED;
          timer_d = '0;
          way_d   = '0;
          flash_d = 1'b0;
        end
        S_ALL_RED: begin
          if (phase_end) begin
            timer_d = '0;
            state_d = pend_q ? S_PED_WALK : S_RED_AMBER;
          end
        end
        S_RED_AMBER: begin
          if (phase_end) begin
            timer_d = '0;
            state_d = S_GREEN;
          end
        end
        S_GREEN: begin
          if (phase_end) begin
            timer_d = '0;
            state_d = S_AMBER;
          end
        end
        S_AMBER: begin
          if (phase_end) begin
            timer_d = '0;
            state_d = S_ALL_RED;
            way_d   = way_next;
          end
        end
        S_PED_WALK: begin
          if (phase_end) begin
            timer_d = '0;
            state_d = S_ALL_RED;
          end
        end
        default: begin
          state_d = S_ALL_RED;
          timer_d = '0;
        end
      endcase
    end
  end

  // Pedestrian latch. A press during the walk itself is ignored, and the
  // clear on walk entry wins over a press on that same edge, so one walk
  // never schedules a second one by itself.
  always_comb begin
    pend_d = pend_q;
    if (state_q != S_PED_WALK && ped_req) begin
      pend_d = 1'b1;
    end
    if (en && state_q == S_ALL_RED && phase_end && pend_q) begin
      pend_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Lamp decode
  // -------------------------------------------------------------------------
  logic is_flash, is_red_amber, is_green, is_amber;

  assign is_flash     = (state_q == S_FLASH);
  assign is_red_amber = (state_q == S_RED_AMBER);
  assign is_green     = (state_q == S_GREEN);
  assign is_amber     = (state_q == S_AMBER);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      logic sel;
      assign sel = (way_q == WAY_W'(gi));
      // Only the selected way ever leaves red; flash turns every red off.
      assign red[gi]   = !is_flash && !(sel && (is_green || is_amber));
      assign amber[gi] = is_flash ? flash_q : (sel && (is_red_amber || is_amber));
      assign green[gi] = sel && is_green;
    end
  endgenerate

  assign walk       = (state_q == S_PED_WALK);
  assign ped_wait   = pend_q;
  assign active_way = way_q;

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for traffic_junction_ctrl. Two instances (2-way defaults and a
// 3-way junction with a short green) share the stimulus; each is compared
// every cycle against a phase/countdown reference model.
// ---------------------------------------------------------------------------
module tb_traffic_junction_ctrl;

  localparam int PH_AR = 0, PH_RA = 1, PH_G = 2, PH_AM = 3, PH_W = 4, PH_F = 5;

  typedef struct {
    int nw; int ra; int g; int am; int ar; int w; int fl;
  } cfg_t;

  typedef struct {
    int ph; int left; int way; bit pend; int fcnt;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en;
  logic       ped_req;

  logic [1:0] red_a, amber_a, green_a;
  logic       walk_a, wait_a;
  logic [0:0] way_a;
  logic [2:0] red_b, amber_b, green_b;
  logic       walk_b, wait_b;
  logic [1:0] way_b;

  int vectors = 0;
  int miscompares = 0;

  cfg_t cfg_a, cfg_b;
  mdl_t m_a, m_b;

  always #5 clk = ~clk;

  traffic_junction_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
    .red(red_a), .amber(amber_a), .green(green_a),
    .walk(walk_a), .ped_wait(wait_a), .active_way(way_a)
  );

  traffic_junction_ctrl #(.NUM_WAYS(3), .GREEN_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
    .red(red_b), .amber(amber_b), .green(green_b),
    .walk(walk_b), .ped_wait(wait_b), .active_way(way_b)
  );

  // ---------------- reference model ----------------
  function automatic int dur(cfg_t c, int ph);
    case (ph)
      PH_AR: return c.ar;
      PH_RA: return c.ra;
      PH_G:  return c.g;
      PH_AM: return c.am;
      PH_W:  return c.w;
      default: return 1;
    endcase
  endfunction

  function automatic mdl_t mreset(cfg_t c);
    mdl_t m;
    m.ph = PH_AR; m.left = c.ar; m.way = 0; m.pend = 1'b0; m.fcnt = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(cfg_t c, mdl_t m, bit e, bit p);
    mdl_t n = m;
    if (m.ph != PH_W && p) n.pend = 1'b1;
    if (e && m.ph == PH_AR && m.left == 1 && m.pend) n.pend = 1'b0;
    if (!e) begin
      if (m.ph != PH_F) begin
        n.ph = PH_F; n.fcnt = 0;
      end else begin
        n.fcnt = m.fcnt + 1;
      end
    end else if (m.ph == PH_F) begin
      n.ph = PH_AR; n.left = c.ar; n.way = 0;
    end else begin
      n.left = m.left - 1;
      if (n.left == 0) begin
        case (m.ph)
          PH_AR: n.ph = m.pend ? PH_W : PH_RA;
          PH_RA: n.ph = PH_G;
          PH_G:  n.ph = PH_AM;
          PH_AM: begin n.ph = PH_AR; n.way = (m.way + 1) % c.nw; end
          default: n.ph = PH_AR;
        endcase
        n.left = dur(c, n.ph);
      end
    end
    return n;
  endfunction

  function automatic int all_mask(cfg_t c);
    return (1 << c.nw) - 1;
  endfunction

  function automatic int exp_red(cfg_t c, mdl_t m);
    if (m.ph == PH_F) return 0;
    if (m.ph == PH_G || m.ph == PH_AM) return all_mask(c) & ~(1 << m.way);
    return all_mask(c);
  endfunction

  function automatic int exp_amber(cfg_t c, mdl_t m);
    if (m.ph == PH_F) return (((m.fcnt / c.fl) % 2) == 0) ? all_mask(c) : 0;
    if (m.ph == PH_RA || m.ph == PH_AM) return 1 << m.way;
    return 0;
  endfunction

  function automatic int exp_green(cfg_t c, mdl_t m);
    return (m.ph == PH_G) ? (1 << m.way) : 0;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, int obs, int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic chk_dut(string nm, cfg_t c, mdl_t m, int r, int a, int g,
                         int w, int pw, int wy);
    int nonred;
    chk({nm, ".red"},        r,  exp_red(c, m));
    chk({nm, ".amber"},      a,  exp_amber(c, m));
    chk({nm, ".green"},      g,  exp_green(c, m));
    chk({nm, ".walk"},       w,  (m.ph == PH_W) ? 1 : 0);
    chk({nm, ".ped_wait"},   pw, int'(m.pend));
    chk({nm, ".active_way"}, wy, m.way);
    nonred = $countones(~r & all_mask(c));
    chk({nm, ".legal"},
        int'((r == 0 || nonred <= 1) && ((g & a) == 0) && !(w != 0 && (g | a) != 0)), 1);
  endtask

  task automatic check_all();
    chk_dut("A", cfg_a, m_a, int'(red_a), int'(amber_a), int'(green_a),
            int'(walk_a), int'(wait_a), int'(way_a));
    chk_dut("B", cfg_b, m_b, int'(red_b), int'(amber_b), int'(green_b),
            int'(walk_b), int'(wait_b), int'(way_b));
    $display("t=%0t en=%0b ped=%0b A r=%b a=%b g=%b w=%0b pw=%0b way=%0d | B r=%b a=%b g=%b w=%0b way=%0d",
             $time, en, ped_req, red_a, amber_a, green_a, walk_a, wait_a, way_a,
             red_b, amber_b, green_b, walk_b, way_b);
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      m_a = mstep(cfg_a, m_a, en, ped_req);
      m_b = mstep(cfg_b, m_b, en, ped_req);
      #1;
      check_all();
    end
  endtask

  // kind: 0 = green on A, 1 = walk on A, 2 = amber-only (normal) on A
  task automatic wait_for(int kind, int budget, string tag);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step(1);
      case (kind)
        0: found = (green_a != 0);
        1: found = walk_a;
        default: found = (amber_a != 0) && (red_a != 2'b11) && (red_a != 2'b00);
      endcase
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL wait_%s: observed timeout expected event within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    cfg_a = '{nw: 2, ra: 2, g: 8, am: 3, ar: 1, w: 6, fl: 4};
    cfg_b = '{nw: 3, ra: 2, g: 4, am: 3, ar: 1, w: 6, fl: 4};
    en = 1'b1;
    ped_req = 1'b0;

    // Reset state.
    #2 rst_n = 1'b0;
    m_a = mreset(cfg_a);
    m_b = mreset(cfg_b);
    #1 check_all();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // Two full 2-way cycles with no pedestrians; back at way 0 all-red.
    step(28);
    chk("A.cycle28_red", int'(red_a), 3);
    chk("A.cycle28_way", int'(way_a), 0);
    step(28);

    // Single-cycle pedestrian press during way-0 green.
    wait_for(0, 40, "green0");
    step(2);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    step(40);

    // Press held across a walk, released before its end: one walk only.
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    wait_for(1, 60, "walk");
    ped_req = 1'b1;
    step(4);
    ped_req = 1'b0;
    step(40);

    // Flash mode entered mid-green, then restored.
    wait_for(0, 40, "green_flash");
    step(2);
    en = 1'b0;
    step(20);
    en = 1'b1;
    step(30);

    // Asynchronous reset during amber.
    wait_for(2, 40, "amber");
    #2 rst_n = 1'b0;
    m_a = mreset(cfg_a);
    m_b = mreset(cfg_b);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;
    step(30);

    // Randomized run.
    for (int i = 0; i < 300; i++) begin
      en      = ($urandom_range(0, 39) != 0) ? ((i % 97) < 90 ? 1'b1 : 1'b0) : 1'b0;
      ped_req = ($urandom_range(0, 9) == 0);
      step(1);
    end
    en = 1'b1;
    ped_req = 1'b0;
    step(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
